// File: rtl/qcl_button_event_if.sv
// Button event bus: debounced level in, classified event pulses and debug state out.
interface qcl_button_event_if;
    logic       btn_i;      // debounced button level, 1 = pressed
    logic       press_o;    // pulse on 0->1 of btn_i
    logic       release_o;  // pulse on 1->0 of btn_i
    logic       short_o;    // single short click confirmed
    logic       double_o;   // double click confirmed
    logic       long_o;     // long press threshold reached
    logic [2:0] state_o;    // classifier state, debug only

    // Side that supplies the button level and consumes the events.
    modport master (
        output btn_i,
        input  press_o, release_o, short_o, double_o, long_o, state_o
    );

    // The classifier itself.
    modport slave (
        input  btn_i,
        output press_o, release_o, short_o, double_o, long_o, state_o
    );
endinterface

// File: rtl/qcl_button_event.sv
// Classifies a clean, clk_i-synchronous button level into single-cycle
// press / release / short-click / double-click / long-press pulses.
// All outputs are registered; the input needs no synchronizer.
module qcl_button_event #(
    parameter int long_cycles_p = 100000000,
    parameter int gap_cycles_p  = 30000000
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    qcl_button_event_if.slave bus
);

    localparam int max_cycles_lp = (long_cycles_p > gap_cycles_p) ? long_cycles_p : gap_cycles_p;
    localparam int cnt_w_lp      = $clog2(max_cycles_lp) + 1;

    // Counter values at which the threshold sample is being taken.
    localparam logic [cnt_w_lp-1:0] long_last_lp = cnt_w_lp'(long_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0] gap_last_lp  = cnt_w_lp'(gap_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0] cnt_one_lp   = cnt_w_lp'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_LONG   = 3'd2,
        ST_WAIT2  = 3'd3,
        ST_PRESS2 = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_btn;
    logic [cnt_w_lp-1:0] r_cnt;
    logic                r_press;
    logic                r_release;
    logic                r_short;
    logic                r_double;
    logic                r_long;

    logic                w_rise;
    logic                w_fall;
    logic [cnt_w_lp-1:0] w_cnt_inc;

    assign w_rise    = bus.btn_i & ~r_btn;
    assign w_fall    = ~bus.btn_i & r_btn;
    // Counter saturates at all-ones so a very long hold never wraps.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : (r_cnt + cnt_one_lp);

    // Edge detection, counter and classification FSM with registered pulses.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= ST_IDLE;
            r_btn     <= 1'b0;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_double  <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_btn     <= bus.btn_i;
            r_press   <= w_rise;
            r_release <= w_fall;
            r_short   <= 1'b0;
            r_double  <= 1'b0;
            r_long    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_PRESS1;
                        r_cnt   <= cnt_one_lp;   // the rise edge is sample 1
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end

                ST_PRESS1: begin
                    if (bus.btn_i) begin
                        if (r_cnt == long_last_lp) begin
                            r_long  <= 1'b1;
                            r_state <= ST_LONG;
                            r_cnt   <= cnt_one_lp;
                        end else begin
                            r_cnt   <= w_cnt_inc;
                        end
                    end else if (w_fall) begin
                        r_state <= ST_WAIT2;
                        r_cnt   <= cnt_one_lp;   // the fall edge is low sample 1
                    end
                end

                ST_LONG: begin
                    if (w_fall) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= cnt_one_lp;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end

                ST_WAIT2: begin
                    if (w_rise) begin
                        r_state <= ST_PRESS2;
                        r_cnt   <= cnt_one_lp;
                    end else if (!bus.btn_i) begin
                        if (r_cnt == gap_last_lp) begin
                            r_short <= 1'b1;
                            r_state <= ST_IDLE;
                            r_cnt   <= cnt_one_lp;
                        end else begin
                            r_cnt   <= w_cnt_inc;
                        end
                    end
                end

                ST_PRESS2: begin
                    // Hold time of the second press is irrelevant; only its release matters.
                    if (w_fall) begin
                        r_double <= 1'b1;
                        r_state  <= ST_IDLE;
                        r_cnt    <= cnt_one_lp;
                    end else begin
                        r_cnt    <= w_cnt_inc;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.press_o   = r_press;
    assign bus.release_o = r_release;
    assign bus.short_o   = r_short;
    assign bus.double_o  = r_double;
    assign bus.long_o    = r_long;
    assign bus.state_o   = r_state;

endmodule

// File: doc/qcl_button_event.md
Name: qcl_button_event

Overview:
- Downstream consumer of the debounce stage: takes a clean, debounced, clk_i-synchronous button level and classifies activity into single-cycle event pulses: press, release, short click, double click, long press.
- Sits between the debounce stage and user logic (mode select, reset-request, menu stepping) on board-level front panels.
- All outputs are registered. No additional synchronizer is used, because the input is already synchronous.

Parameters:
- long_cycles_p, 100000000: number of consecutive clk_i edges with btn_i sampled high that qualifies a long press. The default is 1 s at 100 MHz. Must be >= 2.
- gap_cycles_p, 30000000: number of consecutive clk_i edges with btn_i sampled low, after a first short press, before the click is declared single. The default is 300 ms at 100 MHz. Must be >= 2.
- Derived, localparam cnt_w_lp: $clog2(max(long_cycles_p, gap_cycles_p)) + 1.

Ports:
- clk_i  input  1  system clock.
- reset_n_i  input  1  asynchronous active-low reset.
- btn_i  input  1  debounced button level, 1 = pressed.
- press_o  output  1  one-cycle pulse on every 0->1 of btn_i.
- release_o  output  1  one-cycle pulse on every 1->0 of btn_i.
- short_o  output  1  one-cycle pulse: single short click confirmed.
- double_o  output  1  one-cycle pulse: double click confirmed.
- long_o  output  1  one-cycle pulse: long press threshold reached while held.
- state_o  output  3  current FSM state encoding, for debug.

Behaviour:
- Clock and reset:
  - One clock, clk_i. Reset reset_n_i is asynchronous and active-low.
  - While reset_n_i = 0: state = IDLE, btn_r = 0, cnt = 0, and all pulse outputs = 0.
- Edge detection:
  - btn_r <= btn_i on every edge. rise = btn_i & ~btn_r; fall = ~btn_i & btn_r.
  - Because btn_r resets to 0, a button held through reset release produces rise on the first edge.
- Output timing:
  - Every pulse is registered. It is asserted for exactly the one cycle following the clk_i edge at which the qualifying sample occurred.
  - press_o and release_o fire on every rise and fall, independent of FSM state.
- Counter:
  - cnt is cnt_w_lp bits wide. It is cleared on each state entry and increments by 1 per edge.
  - It saturates and never wraps.
  - The edge that causes state entry counts as sample 1.
- IDLE (0):
  - rise -> PRESS1, cnt <= 1.
  - Otherwise hold.
- PRESS1 (1):
  - btn_i = 1 and cnt == long_cycles_p-1 -> long_o pulse, go to LONG. This means long_cycles_p consecutive high samples, including the rise edge.
  - btn_i = 1 otherwise -> cnt++.
  - fall -> WAIT2, cnt <= 1.
- LONG (2):
  - fall -> IDLE.
  - No further long_o pulses while held.
- WAIT2 (3):
  - rise -> PRESS2.
  - btn_i = 0 and cnt == gap_cycles_p-1 -> short_o pulse, go to IDLE. This means gap_cycles_p consecutive low samples, including the fall edge.
  - btn_i = 0 otherwise -> cnt++.
- PRESS2 (4):
  - fall -> double_o pulse, go to IDLE.
  - The hold duration of the second press is ignored. No long_o is generated from PRESS2.
- Simultaneous events:
  - Each edge samples btn_i as either 0 or 1, so timeout and rise, or threshold and fall, can never coincide on one edge.
  - press_o can coincide with a state transition. press_o and long_o are never in the same cycle, because long_cycles_p >= 2.
- Exclusivity: at most one of short_o, double_o, long_o is asserted per cycle.
- Unused state encodings (5-7) return to IDLE on the next edge, with no pulses.
- Reset mid-operation: an in-flight classification is abandoned with no pulse emitted, and the FSM restarts in IDLE.

Test Plan (long_cycles_p = 8, gap_cycles_p = 5):
- Short click: btn_i high for 3 edges, then low for 5 edges.
  - press_o 1 cycle after the first high edge; release_o after the first low edge.
  - short_o exactly 1 cycle after the 5th low edge.
  - double_o and long_o stay 0.
- Long press: btn_i high for 12 edges.
  - long_o exactly once, 1 cycle after the 8th high edge.
  - On release: release_o only. state_o returns to 0.
- Long threshold boundary: high for exactly 7 edges, then low.
  - No long_o. short_o after 5 low edges.
- Double click: high 2, low 4, high 2, low.
  - Two press_o pulses and two release_o pulses.
  - double_o 1 cycle after the second fall. No short_o.
- Gap boundary: high 2, low 5, high 2, low 5.
  - Two short_o pulses. No double_o.
- Reset mid-operation: assert reset_n_i = 0 in WAIT2 after 3 low edges, then release.
  - All outputs 0 immediately (asynchronous). state_o = 0.
  - No short_o afterwards.
- Held through reset: btn_i = 1 while reset_n_i is released.
  - press_o on the first edge. long_o after 8 edges.
